// File: rtl/imem_boot_loader.sv
// Streams a little-endian byte image into instruction memory from word 0,
// holding the CPU in reset until the last word has been written.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam logic [2:0] S_HDR0      = 3'd0;
  localparam logic [2:0] S_HDR1      = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_DONE_WAIT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] count_n;
  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;
  logic        xfer;
  logic        last_word;
  logic [16:0] n_full;

  assign in_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
  assign xfer     = in_valid && in_ready;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign n_full   = {1'b0, in_data, count_n[7:0]};

  // words_loaded already counts every earlier word when this word's 4th byte lands.
  assign last_word = ({1'b0, words_loaded} + 17'd1) == {1'b0, count_n};

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_HDR0: if (xfer) state_nx = S_HDR1;
      S_HDR1: begin
        if (xfer) begin
          if (n_full > DEPTH)      state_nx = S_ERROR;
          else if (n_full == '0)   state_nx = S_DONE_WAIT;
          else                     state_nx = S_DATA;
        end
      end
      S_DATA: if (xfer && byte_cnt == 2'd3 && last_word) state_nx = S_DONE_WAIT;
      S_DONE_WAIT: state_nx = S_DONE;
      S_DONE, S_ERROR: if (reload) state_nx = S_HDR0;
      default: state_nx = S_HDR0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_HDR0;
      count_n      <= '0;
      byte_cnt     <= '0;
      shift_q      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
    end else begin
      state     <= state_nx;
      cpu_reset <= (state_nx != S_DONE);
      mem_we    <= 1'b0;

      if (mem_we) begin
        mem_addr     <= mem_addr + ADDR_WIDTH'(1);
        words_loaded <= words_loaded + 16'd1;
      end

      case (state)
        S_HDR0: if (xfer) count_n[7:0]  <= in_data;
        S_HDR1: if (xfer) count_n[15:8] <= in_data;
        S_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {in_data, shift_q};
            end else begin
              shift_q <= {in_data, shift_q[23:8]};
            end
          end
        end
        S_DONE, S_ERROR: begin
          // Leaving for HDR0 starts a fresh image from word 0.
          if (reload) begin
            count_n      <= '0;
            byte_cnt     <= '0;
            mem_addr     <= '0;
            words_loaded <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: vector table, hand-timed corner
// sequences and randomized images checked against a frame-level model.
module tb_imem_boot_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic        prev_we = 1'b0;

  typedef struct {
    logic [127:0] bytes;
    int           len;
    int           gap;
    logic         exp_done;
    logic         exp_error;
    logic [15:0]  exp_words;
  } vec_t;

  vec_t vecs[6];

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(32'(mem_addr));
      got_data.push_back(mem_wdata);
      check("we_back_to_back", {31'b0, prev_we}, 32'd0);
    end
    prev_we <= mem_we;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},     {31'b0, mem_we},    32'd0);
    check({tag, "_addr"},   32'(mem_addr),      32'd0);
    check({tag, "_wdata"},  mem_wdata,          32'd0);
    check({tag, "_cpurst"}, {31'b0, cpu_reset}, 32'd1);
    check({tag, "_done"},   {31'b0, done},      32'd0);
    check({tag, "_error"},  {31'b0, error},     32'd0);
    check({tag, "_words"},  32'(words_loaded),  32'd0);
    check({tag, "_ready"},  {31'b0, in_ready},  32'd1);
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b1;
    in_valid = 1'b0;
    reload   = 1'b0;
    @(negedge clk);
    check_reset_vals(tag);
    reset = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Frame-level reference: header count, then little-endian words from address 0.
  task automatic prep_model();
    int n;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    got_addr.delete();
    got_data.delete();
    n = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = 32'(stream_q[2 + 4*i])
          + 32'(stream_q[3 + 4*i]) * 32'd256
          + 32'(stream_q[4 + 4*i]) * 32'd65536
          + 32'(stream_q[5 + 4*i]) * 32'd16777216;
        exp_addr.push_back(32'(i));
        exp_data.push_back(w);
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int m;
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_waddr"}, got_addr[i], exp_addr[i]);
      check({tag, "_wdata"}, got_data[i], exp_data[i]);
    end
  endtask

  // gap < 0 selects a random 0..2 idle cycles between bytes.
  task automatic run_stream(input string tag, input int gap);
    int g;
    prep_model();
    for (int i = 0; i < stream_q.size(); i++) begin
      send_byte(stream_q[i]);
      if (i != stream_q.size() - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        idle(g);
      end
    end
    idle(3);
    compare_writes(tag);
  endtask

  initial begin
    logic [31:0] plan_words[3];
    logic [127:0] bv;
    int n;
    plan_words[0] = 32'h00500093;
    plan_words[1] = 32'h00A00113;
    plan_words[2] = 32'h002081B3;

    vecs[0] = '{bytes: 128'h0300_9300_5000_1301_A000_B381_2000_0000, len: 14, gap: 0,
                exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd3};
    vecs[1] = '{bytes: 128'h0300_9300_5000_1301_A000_B381_2000_0000, len: 14, gap: 1,
                exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd3};
    vecs[2] = '{bytes: 128'h0, len: 2, gap: 0,
                exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd0};
    vecs[3] = '{bytes: 128'h0101_0000_0000_0000_0000_0000_0000_0000, len: 2, gap: 0,
                exp_done: 1'b0, exp_error: 1'b1, exp_words: 16'd0};
    vecs[4] = '{bytes: 128'h0100_EFBE_ADDE_0000_0000_0000_0000_0000, len: 6, gap: 2,
                exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd1};
    vecs[5] = '{bytes: 128'h0200_1122_3344_5566_7788_0000_0000_0000, len: 10, gap: 3,
                exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd2};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    @(negedge clk);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      do_reset("tbl_rst");
      stream_q.delete();
      bv = vecs[i].bytes;
      for (int k = 0; k < vecs[i].len; k++) stream_q.push_back(bv[127 - 8*k -: 8]);
      run_stream("tbl", vecs[i].gap);
      check("tbl_done",   {31'b0, done},      {31'b0, vecs[i].exp_done});
      check("tbl_error",  {31'b0, error},     {31'b0, vecs[i].exp_error});
      check("tbl_words",  32'(words_loaded),  32'(vecs[i].exp_words));
      check("tbl_cpurst", {31'b0, cpu_reset}, {31'b0, ~vecs[i].exp_done});
      check("tbl_ready",  {31'b0, in_ready},  32'd0);
    end

    // Exact write and release timing, N = 3 back-to-back.
    do_reset("a_rst");
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 12; i++) begin
      bv = {plan_words[i/4], 96'b0};
      send_byte(bv[127 - 8*(3 - (i % 4)) -: 8]);
      if (i % 4 == 3) begin
        check("a_we",    {31'b0, mem_we}, 32'd1);
        check("a_addr",  32'(mem_addr),   32'(i / 4));
        check("a_wdata", mem_wdata,       plan_words[i/4]);
      end else begin
        check("a_we_idle", {31'b0, mem_we}, 32'd0);
      end
    end
    check("a_cpurst_t1", {31'b0, cpu_reset}, 32'd1);
    check("a_done_t1",   {31'b0, done},      32'd0);
    idle(1);
    check("a_cpurst_t2", {31'b0, cpu_reset}, 32'd0);
    check("a_done_t2",   {31'b0, done},      32'd1);
    check("a_words",     32'(words_loaded),  32'd3);

    // N = 0 timing.
    do_reset("b_rst");
    send_byte(8'h00);
    send_byte(8'h00);
    check("b_done_t1",  {31'b0, done},     32'd0);
    check("b_ready_t1", {31'b0, in_ready}, 32'd0);
    idle(1);
    check("b_done_t2",   {31'b0, done},      32'd1);
    check("b_cpurst_t2", {31'b0, cpu_reset}, 32'd0);

    // N = 257 error, byte offered while not ready, then reload with N = DEPTH.
    do_reset("c_rst");
    got_addr.delete();
    got_data.delete();
    send_byte(8'h01);
    send_byte(8'h01);
    check("c_error",  {31'b0, error},     32'd1);
    check("c_ready",  {31'b0, in_ready},  32'd0);
    check("c_cpurst", {31'b0, cpu_reset}, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    idle(4);
    in_valid = 1'b0;
    check("c_error_hold", {31'b0, error}, 32'd1);
    check("c_nowrite", 32'(got_addr.size()), 32'd0);
    pulse_reload();
    check("c_error_clr", {31'b0, error},     32'd0);
    check("c_ready_clr", {31'b0, in_ready},  32'd1);
    check("c_cpurst_hdr", {31'b0, cpu_reset}, 32'd1);
    stream_q.delete();
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h01);
    for (int i = 0; i < 4 * DEPTH; i++) stream_q.push_back(8'($urandom));
    run_stream("c_full", 0);
    check("c_full_done",  {31'b0, done},     32'd1);
    check("c_full_words", 32'(words_loaded), 32'(DEPTH));

    // Reset after 6 data bytes of an N = 2 load.
    do_reset("d_rst0");
    got_addr.delete();
    got_data.delete();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset("d_rst1");
    idle(3);
    check("d_nwrites", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() > 0) begin
      check("d_addr0", got_addr[0], 32'd0);
      check("d_data0", got_data[0], 32'h12345678);
    end
    stream_q.delete();
    stream_q = '{8'h01, 8'h00, 8'h21, 8'h43, 8'h65, 8'h87};
    run_stream("d_fresh", 0);
    check("d_done",   {31'b0, done},      32'd1);
    check("d_cpurst", {31'b0, cpu_reset}, 32'd0);

    // Reload from DONE, then reload pulsed mid-DATA must be ignored.
    pulse_reload();
    check("e_cpurst", {31'b0, cpu_reset}, 32'd1);
    check("e_done",   {31'b0, done},      32'd0);
    check("e_words",  32'(words_loaded),  32'd0);
    stream_q.delete();
    stream_q = '{8'h01, 8'h00, 8'hC0, 8'hFF, 8'hEE, 8'h0D};
    prep_model();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hC0);
    reload = 1'b1;
    send_byte(8'hFF);
    reload = 1'b0;
    send_byte(8'hEE);
    send_byte(8'h0D);
    idle(3);
    compare_writes("e");
    check("e_done_end", {31'b0, done}, 32'd1);

    // Randomized images with random backpressure.
    for (int it = 0; it < 20; it++) begin
      if (it % 2 == 0) do_reset("r_rst");
      else pulse_reload();
      n = int'($urandom_range(1, 8));
      stream_q.delete();
      stream_q.push_back(8'(n));
      stream_q.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
      run_stream("rnd", -1);
      check("rnd_done",   {31'b0, done},      32'd1);
      check("rnd_words",  32'(words_loaded),  32'(n));
      check("rnd_cpurst", {31'b0, cpu_reset}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
